vend_credit_fsm: RTL
====================

VEND_CREDIT_FSM -- requirements
Module: vend_credit_fsm

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  N_PROD, 4, number of selectable products.
  COIN_W, 4, coin value width (Rs).
  CREDIT_W, 8, credit accumulator width (Rs).
  PRICE_TABLE, {8'd10,8'd5,8'd1,8'd2}, packed N_PROD x CREDIT_W prices; product i at [i*CREDIT_W +: CREDIT_W]; defaults are filter=2, black=1, Bru=5, nescafe=10.
  DISP_CYC, 4, cycles dispenser held high.
  TIMEOUT_CYC, 255, idle cycles in COLLECT before auto-refund.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  input  1  rising-edge clock.
  rst  input  1  asynchronous active-low reset.
  coin_valid  input  1  coin strobe; one coin per high cycle.
  coin_val  input  COIN_W  coin value.
  sel_valid  input  1  product-select strobe.
  sel  input  $clog2(N_PROD)  product index.
  cancel  input  1  refund request.
  credit  output  CREDIT_W  current credit.
  dispenser  output  1  dispense command.
  disp_prod  output  $clog2(N_PROD)  product being dispensed.
  change_valid  output  1  change strobe.
  change_val  output  CREDIT_W  change amount.
  coin_rej  output  1  coin rejected pulse.
  LED_Yellow  output  1  dispensing.
  LED_Green  output  1  ready (IDLE).

Function
REQ-003 The FSM SHALL have states IDLE, COLLECT, DISPENSE, CHANGE; all outputs registered.
REQ-004 IDLE: LED_Green=1; coin_valid with coin_val!=0 SHALL add coin_val to credit and move to COLLECT; sel_valid and cancel are ignored.
REQ-005 COLLECT: an accepted coin SHALL add to credit next cycle; if credit+coin_val exceeds 2^CREDIT_W-1, the coin SHALL be rejected: credit unchanged, coin_rej high for 1 cycle.
REQ-006 sel_valid with sel<N_PROD and (credit + same-cycle accepted coin) >= price[sel] SHALL latch disp_prod, subtract the price from credit, and enter DISPENSE next cycle; otherwise the selection is ignored.
REQ-007 Latency: selection accepted at cycle N gives dispenser=1 and LED_Yellow=1 for cycles N+1..N+DISP_CYC exactly.
REQ-008 cancel in COLLECT SHALL take priority over sel_valid; any coin accepted the same cycle is included, then the FSM enters CHANGE.
REQ-009 A timeout counter SHALL clear on any coin_valid or sel_valid in COLLECT; reaching TIMEOUT_CYC SHALL behave as cancel.
REQ-010 coin_valid in DISPENSE or CHANGE SHALL be rejected with a coin_rej pulse; sel_valid and cancel are ignored.
REQ-011 CHANGE: change_valid=1 and change_val=credit for exactly 1 cycle; credit SHALL clear; next state IDLE.
REQ-012 At DISPENSE end: credit==0 goes to IDLE; credit>0 follows REQ-016.

Reset
REQ-013 rst low SHALL asynchronously force state IDLE, credit=0, counters=0, and all outputs 0 except LED_Green=1.
REQ-014 Reset mid-DISPENSE or mid-CHANGE SHALL abort without a change_valid pulse; credit is discarded.
REQ-015 The first coin SHALL be accepted on the first rising clk after rst deasserts.

Configuration
REQ-016 Macro CHANGE_RETURN_EN: when defined, residual credit after DISPENSE SHALL go to CHANGE and be returned; when undefined, residual credit SHALL be retained and the FSM SHALL return to COLLECT for further purchases (cancel/timeout refund still apply).

Verification
REQ-017 coins 5,5 then sel=3 -> credit 10->0, dispenser high 4 cycles from cycle after sel, disp_prod=3, no change_valid.
REQ-018 coin 10, sel=1 -> dispense 4 cycles; with CHANGE_RETURN_EN change_valid 1 cycle, change_val=9, credit 0; without it credit=9, state COLLECT.
REQ-019 credit 250, coin 10 -> coin_rej 1-cycle pulse, credit stays 250.
REQ-020 credit 1, same cycle coin 1 and sel=0 -> accepted, credit 0, dispense starts next cycle.
REQ-021 coin 2, then 255 idle cycles -> change_valid with change_val=2, return to IDLE.
REQ-022 rst low during cycle 2 of dispense -> dispenser=0, credit=0, LED_Green=1 immediately, no change_valid.

Source files
------------

// File: rtl/vend_credit_fsm.sv
`timescale 1ns/1ps
// Vending-machine credit FSM: accumulates coins, dispenses priced products, refunds on cancel/timeout.
// Build option CHANGE_RETURN_EN: refund residual credit after each dispense instead of keeping it.
module vend_credit_fsm #(
   parameter int N_PROD = 4,
   parameter int COIN_W = 4,
   parameter int CREDIT_W = 8,
   parameter logic [N_PROD*CREDIT_W-1:0] PRICE_TABLE = {8'd10, 8'd5, 8'd1, 8'd2},
   parameter int DISP_CYC = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      coin_valid,
   input  logic [COIN_W-1:0]         coin_val,
   input  logic                      sel_valid,
   input  logic [$clog2(N_PROD)-1:0] sel,
   input  logic                      cancel,
   output logic [CREDIT_W-1:0]       credit,
   output logic                      dispenser,
   output logic [$clog2(N_PROD)-1:0] disp_prod,
   output logic                      change_valid,
   output logic [CREDIT_W-1:0]       change_val,
   output logic                      coin_rej,
   output logic                      LED_Yellow,
   output logic                      LED_Green
);

   localparam int SEL_W  = $clog2(N_PROD);
   localparam int DCNT_W = $clog2(DISP_CYC + 1);
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TCNT_W-1:0]   tmo_q, tmo_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [SEL_W-1:0]    disp_prod_q, disp_prod_d;
   logic                dispenser_q, dispenser_d;
   logic                change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0] change_val_q, change_val_d;
   logic                coin_rej_q, coin_rej_d;
   logic                led_green_q, led_green_d;

   logic [CREDIT_W-1:0] price_arr [N_PROD];
   logic [CREDIT_W-1:0] price_sel;
   logic                sel_ok;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] collect_total;
   logic                activity;
   logic                timeout_hit;
   logic                rej_ev;
   logic [CREDIT_W-1:0] refund_amt;

   genvar gi;
   generate
      for (gi = 0; gi < N_PROD; gi++) begin : g_price
         assign price_arr[gi] = PRICE_TABLE[gi*CREDIT_W +: CREDIT_W];
      end
      // A full-range select index can never point past the table.
      if ((1 << SEL_W) == N_PROD) begin : g_sel_full
         assign sel_ok = 1'b1;
      end else begin : g_sel_range
         assign sel_ok = ({1'b0, sel} < (SEL_W + 1)'(N_PROD));
      end
   endgenerate

   assign price_sel     = price_arr[sel];
   assign coin_sum      = {1'b0, credit_q} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, coin_val};
   assign coin_fits     = ~coin_sum[CREDIT_W];
   assign collect_total = (coin_valid && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit_q;
   assign activity      = coin_valid | sel_valid;
   assign timeout_hit   = ~activity && (tmo_q == TCNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         tmo_q          <= '0;
         dcnt_q         <= '0;
         disp_prod_q    <= '0;
         dispenser_q    <= 1'b0;
         change_valid_q <= 1'b0;
         change_val_q   <= '0;
         coin_rej_q     <= 1'b0;
         led_green_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         tmo_q          <= tmo_d;
         dcnt_q         <= dcnt_d;
         disp_prod_q    <= disp_prod_d;
         dispenser_q    <= dispenser_d;
         change_valid_q <= change_valid_d;
         change_val_q   <= change_val_d;
         coin_rej_q     <= coin_rej_d;
         led_green_q    <= led_green_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      tmo_d       = tmo_q;
      dcnt_d      = dcnt_q;
      disp_prod_d = disp_prod_q;
      rej_ev      = 1'b0;
      refund_amt  = '0;
      case (state_q)
         S_IDLE: begin
            if (coin_valid && (coin_val != '0)) begin
               credit_d = coin_sum[CREDIT_W-1:0];
               tmo_d    = '0;
               state_d  = S_COLLECT;
            end
         end
         S_COLLECT: begin
            rej_ev = coin_valid && !coin_fits;
            // Cancel (or timeout) wins over a same-cycle selection.
            if (cancel || timeout_hit) begin
               refund_amt = collect_total;
               credit_d   = '0;
               state_d    = S_CHANGE;
            end else if (sel_valid && sel_ok && (collect_total >= price_sel)) begin
               credit_d    = collect_total - price_sel;
               disp_prod_d = sel;
               dcnt_d      = '0;
               state_d     = S_DISPENSE;
            end else begin
               credit_d = collect_total;
               tmo_d    = activity ? '0 : tmo_q + TCNT_W'(1);
            end
         end
         S_DISPENSE: begin
            rej_ev = coin_valid;
            if (dcnt_q == DCNT_W'(DISP_CYC - 1)) begin
               if (credit_q == '0) begin
                  state_d = S_IDLE;
               end else begin
`ifdef CHANGE_RETURN_EN
                  refund_amt = credit_q;
                  credit_d   = '0;
                  state_d    = S_CHANGE;
`else
                  tmo_d   = '0;
                  state_d = S_COLLECT;
`endif
               end
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         default: begin
            rej_ev  = coin_valid;
            state_d = S_IDLE;
         end
      endcase
   end

   // CHANGE always exits after one cycle, so state_d==S_CHANGE marks only the entry edge.
   always_comb begin
      dispenser_d    = (state_d == S_DISPENSE);
      led_green_d    = (state_d == S_IDLE);
      change_valid_d = (state_d == S_CHANGE);
      change_val_d   = change_valid_d ? refund_amt : '0;
      coin_rej_d     = rej_ev;
   end

   assign credit       = credit_q;
   assign dispenser    = dispenser_q;
   assign disp_prod    = disp_prod_q;
   assign change_valid = change_valid_q;
   assign change_val   = change_val_q;
   assign coin_rej     = coin_rej_q;
   assign LED_Yellow   = dispenser_q;
   assign LED_Green    = led_green_q;

endmodule
